// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: accepts step commands and drives a Gray-coded A/B pair at a set edge rate.
// Define QUAD_GEN_POSITION_EN to add the signed edge-count output `position`.
module quad_encoder_gen #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 8
`ifdef QUAD_GEN_POSITION_EN
  ,
  parameter int POS_W    = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic                enc_a,
  output logic                enc_b,
  output logic                busy,
  output logic                done
`ifdef QUAD_GEN_POSITION_EN
  ,
  output logic [POS_W-1:0]    position
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic                dir_q, dir_d;
  logic [STEPS_W-1:0]  rem_q, rem_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] div_q, div_d;
  logic                enc_a_q, enc_b_q;
  logic [1:0]          ab_d;
  logic                edge_due;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    period_d = period_q;
    div_d    = div_q;
    edge_due = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          rem_d    = cmd_steps;
          period_d = (period == '0) ? PERIOD_W'(1) : period;
          div_d    = period_d;
          state_d  = (cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // The edge falls on the clock where the divider would hit zero.
        if (div_q <= PERIOD_W'(1)) begin
          edge_due = 1'b1;
          div_d    = period_q;
          rem_d    = rem_q - STEPS_W'(1);
          if (rem_q == STEPS_W'(1)) state_d = DONE;
        end else begin
          div_d = div_q - PERIOD_W'(1);
        end
        if (abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (edge_due) phase_d = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
  end

  always_comb begin
    ab_d = 2'b00;
    unique case (phase_d)
      2'd0: ab_d = 2'b00;
      2'd1: ab_d = 2'b10;
      2'd2: ab_d = 2'b11;
      2'd3: ab_d = 2'b01;
      default: ab_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= 2'd0;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      period_q <= '0;
      div_q    <= '0;
      enc_a_q  <= 1'b0;
      enc_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      period_q <= period_d;
      div_q    <= div_d;
      enc_a_q  <= ab_d[1];
      enc_b_q  <= ab_d[0];
    end
  end

`ifdef QUAD_GEN_POSITION_EN
  logic [POS_W-1:0] position_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position_q <= '0;
    end else if (edge_due) begin
      position_q <= dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end
  end

  assign position = position_q;
`endif

  assign enc_a     = enc_a_q;
  assign enc_b     = enc_b_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule
